// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter sharing one combinational 64-bit ALU among NUM_REQ requesters.
// Latency : accept at cycle 0 -> resp_valid from cycle 2 (MUL: from cycle 1+MUL_CYCLES).
// Backpres: resp_ready=0 parks the FSM in RESP; no grant is made and resp_* stay frozen.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           per-requester request handshake (ready is one-hot or zero)
//   req_A/req_B/req_op            packed per-requester operands and opcode (requester i at slice i)
//   resp_valid/resp_ready         response handshake
//   resp_id/resp_result/resp_flags owner index, captured result, {carry, overflow, negative, zero}
//   alu_A/alu_B/alu_operation     registered operands and opcode driven to the shared ALU
//   alu_output, *_flag            combinational ALU result and flags
module alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_A,
    input  logic [NUM_REQ*64-1:0] req_B,
    input  logic [NUM_REQ*8-1:0]  req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [63:0]           resp_result,
    output logic [3:0]            resp_flags,
    output logic [63:0]           alu_A,
    output logic [63:0]           alu_B,
    output logic [7:0]            alu_operation,
    input  logic [63:0]           alu_output,
    input  logic                  zero_flag,
    input  logic                  negative_flag,
    input  logic                  overflow_flag,
    input  logic                  carry_flag
);

    localparam logic [7:0] OP_MUL = 8'h03;

    // Counter only needs to hold MUL_CYCLES-1; keep at least one bit.
    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  op;
    } alu_req_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  exec_cnt;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W:0]     cand;
    alu_req_t          win_req;

    logic              accept;
    logic              capture;
    logic              cnt_dec;

    // Unpacked views of the packed request buses so the winner can be muxed by index.
    logic [63:0] a_arr  [NUM_REQ];
    logic [63:0] b_arr  [NUM_REQ];
    logic [7:0]  op_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]  = req_A[gi*64 +: 64];
        assign b_arr[gi]  = req_B[gi*64 +: 64];
        assign op_arr[gi] = req_op[gi*8 +: 8];
    end

    // Round-robin search: scan last_grant+1, +2, ... with wrap, first valid wins.
    // The candidate carries one spare bit so the sum never overflows before the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_req.a  = a_arr[win_idx];
        win_req.b  = b_arr[win_idx];
        win_req.op = op_arr[win_idx];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. req_ready is masked while rst is high so a
    // requester never sees an accept that the held-in-reset registers would ignore.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    accept             = 1'b1;
                    state_d            = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_cnt != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                // Returning to IDLE first means a new grant is at least one cycle later.
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ALU operand registers, grant history and execute counter.
    // Operands only move on an accept edge, so the ALU sees stable inputs for the
    // whole EXEC phase and keeps its last inputs while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_A         <= '0;
            alu_B         <= '0;
            alu_operation <= '0;
            resp_id       <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            exec_cnt      <= '0;
        end else if (accept) begin
            alu_A         <= win_req.a;
            alu_B         <= win_req.b;
            alu_operation <= win_req.op;
            resp_id       <= win_idx;
            last_grant    <= win_idx;
            exec_cnt      <= (win_req.op == OP_MUL) ? MUL_LOAD : '0;
        end else if (cnt_dec) begin
            exec_cnt      <= exec_cnt - CNT_W'(1);
        end
    end

    // Result capture on the last execute cycle; flags pass through untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_result <= '0;
            resp_flags  <= '0;
        end else if (capture) begin
            resp_result <= alu_output;
            resp_flags  <= {carry_flag, overflow_flag, negative_flag, zero_flag};
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 64-bit ALU of DJ Core 1 among NUM_REQ requesters (decode/issue ports, address-generation, debug). Each transaction uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers operands and opcode into the ALU, and holds MUL for a configurable number of cycles. It returns result plus flags tagged with the requester index.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index, = clog2(NUM_REQ)
- MUL_CYCLES, 3, execute cycles granted to opcode 8'h03 (MUL), ≥1; all other opcodes take 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_A  in  NUM_REQ*64  operand A, requester i at [64i+63:64i]
- req_B  in  NUM_REQ*64  operand B, same packing
- req_op  in  NUM_REQ*8  ALU opcode, requester i at [8i+7:8i]
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  ID_W  index of requester owning the response
- resp_result  out  64  captured ALU result
- resp_flags  out  4  {carry, overflow, negative, zero} captured with result
- alu_A, alu_B  out  64  registered operands driven to ALU
- alu_operation  out  8  registered opcode driven to ALU
- alu_output  in  64  ALU result
- zero_flag, negative_flag, overflow_flag, carry_flag  in  1 each  ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Winner = first requester with req_valid=1, searching from last_grant+1 upward with wrap.
  - req_ready[winner]=1, combinational from req_valid and state. All other bits are 0. All bits are 0 outside IDLE.
  - On the handshake edge: latch A, B and op into alu_A, alu_B and alu_operation; latch winner into resp_id; set last_grant=winner; load exec_cnt = (op==8'h03) ? MUL_CYCLES-1 : 0; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC
  - ALU inputs are stable from the registers.
  - If exec_cnt≠0: decrement it.
  - Otherwise: capture alu_output into resp_result and the flags into resp_flags; go to RESP.
- RESP
  - resp_valid=1. resp_id, resp_result and resp_flags are stable.
  - On resp_valid&resp_ready: go to IDLE. A new grant may happen on the next cycle, not the same one.
- alu_A, alu_B and alu_operation hold their last values outside EXEC; they change only on an accept edge.
- Opcodes are passed through unmodified, including undefined ones (ALU returns 0) and counter ops 0x0D–0x0F. For counter ops, resp_result carries whatever the ALU drives.
- The arbiter does not gate or modify flags. For non-arithmetic ops, overflow is reported exactly as the ALU computes it.
- Requesters must hold req_valid and operands stable until req_ready. The arbiter never drops a pending request.

## Timing
- Reset (async assert, sync release), all outputs and registers go to 0:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority)
  - req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_flags=0
  - alu_A=0, alu_B=0, alu_operation=0, exec_cnt=0
- Latency, with the accept edge at cycle 0:
  - non-MUL: resp_valid high from cycle 2
  - MUL: resp_valid high from cycle 1+MUL_CYCLES
- Throughput: at most one transaction per 3 cycles (non-MUL) with resp_ready tied high.
- Back-pressure: resp_ready=0 holds RESP indefinitely. No new grant is made and all resp_* outputs stay stable.
- Simultaneous requests: exactly one grant per IDLE cycle. Rotation guarantees each requester waits at most NUM_REQ-1 transactions.
- Wrap-around: when last_grant=NUM_REQ-1, the search starts at 0.
- Reset mid-EXEC or mid-RESP aborts the transaction with no response. The requester already saw its handshake and must not expect a reply.
- MUL_CYCLES=1: MUL timing equals non-MUL timing.

## Test plan
- Single ADD: req0 A=5, B=7, op=01, resp_ready=1 → req_ready[0] at cycle 0; resp_valid at cycle 2; resp_result=12, flags=4'b0000, resp_id=0.
- Round-robin: all four valid continuously with op=02, A=i, B=1 → grants in order 0,1,2,3,0; results i-1 (req0 gives 0xFFFF_FFFF_FFFF_FFFF with negative=1; req1 gives 0 with zero=1).
- MUL latency: MUL_CYCLES=3, A=3, B=4 → resp_valid at cycle 4, result 12; alu_operation held at 8'h03 through cycles 1–3.
- Back-pressure: resp_ready=0 for 10 cycles with req1 valid → resp_* stable; req_ready stays 0; req1 is granted the cycle after the response handshake.
- Overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, op=01 → result 64'h8000_0000_0000_0000; flags overflow=1, negative=1, zero=0.
- Reset mid-EXEC: assert rst during MUL execute → all outputs 0 immediately; no resp_valid afterward; next request from req0 wins first.
